// File: rtl/port_frame_transmitter_pkg.sv
// rtl/port_frame_transmitter_pkg.sv - shared types and helpers for the port frame transmitter
package port_frame_transmitter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_type;

    function automatic int calcBeatsPerWord(input int parrallelWidth, input int serialWidth);
        return parrallelWidth / serialWidth;
    endfunction

endpackage

// File: rtl/port_frame_transmitter_tx_beat_shifter.sv
// rtl/port_frame_transmitter_tx_beat_shifter.sv - word shift register and beat counter with pause hold
module port_frame_transmitter_tx_beat_shifter #(
    parameter int serialWidth    = 8,
    parameter int parrallelWidth = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      load,
    input  logic [parrallelWidth-1:0] loadData,
    input  logic                      pause,
    output logic [serialWidth-1:0]    beat,
    output logic                      firstBeat,
    output logic                      lastBeat
);
    import port_frame_transmitter_pkg::*;

    localparam int beatsPerWord = calcBeatsPerWord(parrallelWidth, serialWidth);
    localparam int cntW = (beatsPerWord > 1) ? $clog2(beatsPerWord) : 1;

    logic [parrallelWidth-1:0] shiftReg;
    logic [cntW-1:0]           beatCnt;
    logic                      active;

    // load wins over advance so a new word can follow the last beat without a bubble
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shiftReg <= '0;
            beatCnt  <= '0;
            active   <= 1'b0;
        end else if (load) begin
            shiftReg <= loadData;
            beatCnt  <= '0;
            active   <= 1'b1;
        end else if (active && !pause) begin
            if (lastBeat) begin
                active <= 1'b0;
            end else begin
                shiftReg <= shiftReg >> serialWidth;
                beatCnt  <= beatCnt + 1'b1;
            end
        end
    end

    assign beat      = shiftReg[serialWidth-1:0];
    assign firstBeat = (beatCnt == '0);
    assign lastBeat  = (beatCnt == cntW'(beatsPerWord - 1));

endmodule

// File: rtl/port_frame_transmitter.sv
// rtl/port_frame_transmitter.sv - framed word-to-beat serialiser for one switch port; PORT_TX_STATS_EN adds counters
module port_frame_transmitter #(
    parameter int serialWidth      = 8,
    parameter int parrallelWidth   = 32,
    parameter int interFrameGap    = 2,
    parameter int maxWordsPerFrame = 64
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [parrallelWidth-1:0] wordData,
    input  logic                      wordValid,
    output logic                      wordReady,
    input  logic                      wordSof,
    input  logic                      wordEof,
    input  logic                      wordError,
    input  logic                      pause,
    output logic [serialWidth-1:0]    pushData,
    output logic                      push,
    output logic                      pushDataStartOfFrame,
    output logic                      pushDataEndOfFrame,
    output logic                      pushDataError,
    output logic                      busy
`ifdef PORT_TX_STATS_EN
    ,
    output logic [31:0]               txFrameCount,
    output logic [31:0]               txErrorFrameCount,
    output logic [31:0]               txDroppedWordCount
`endif
);
    import port_frame_transmitter_pkg::*;

    localparam int countW  = $clog2(maxWordsPerFrame + 1);
    localparam int gapW    = (interFrameGap > 1) ? $clog2(interFrameGap) : 1;
    localparam int gapLoad = (interFrameGap > 0) ? interFrameGap - 1 : 0;
    localparam bit gapOn   = (interFrameGap > 0);

    tx_state_type state, stateNext;

    logic                   outOfReset;
    logic                   inFrame, dropping, frameErr;
    logic [countW-1:0]      wordCount, nextCount;
    logic                   curSof, curEof, curErr;
    logic [gapW-1:0]        gapCnt;
    logic [serialWidth-1:0] beat;
    logic                   firstBeat, lastBeat;
    logic                   accept, drop, load;
    logic                   sofStart, lateSof, forcedEnd, wordEnds, wordBad;

    port_frame_transmitter_tx_beat_shifter #(
        .serialWidth   (serialWidth),
        .parrallelWidth(parrallelWidth)
    ) u_shifter (
        .clk      (clk),
        .rstn     (rstn),
        .load     (load),
        .loadData (wordData),
        .pause    (pause),
        .beat     (beat),
        .firstBeat(firstBeat),
        .lastBeat (lastBeat)
    );

    // a frame-ending last beat only opens the port when there is no gap to enforce
    assign wordReady = (state == IDLE && outOfReset) ||
                       (state == SHIFT && !pause && lastBeat && !(curEof && gapOn));

    assign accept    = wordValid && wordReady;
    assign drop      = dropping || (!inFrame && !wordSof);
    assign load      = accept && !drop;
    assign sofStart  = wordSof && !inFrame;
    assign lateSof   = wordSof && inFrame;
    assign nextCount = inFrame ? wordCount + 1'b1 : countW'(1);
    assign forcedEnd = (nextCount == countW'(maxWordsPerFrame)) && !wordEof;
    assign wordEnds  = wordEof || forcedEnd;
    assign wordBad   = (wordEof && wordError) || frameErr || lateSof || forcedEnd;
    assign busy      = (state != IDLE) || inFrame;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext            = state;
        push                 = 1'b0;
        pushData             = '0;
        pushDataStartOfFrame = 1'b0;
        pushDataEndOfFrame   = 1'b0;
        pushDataError        = 1'b0;
        case (state)
            IDLE: begin
                if (load) stateNext = SHIFT;
            end
            SHIFT: begin
                push                 = !pause;
                pushData             = pause ? '0 : beat;
                pushDataStartOfFrame = !pause && firstBeat && curSof;
                pushDataEndOfFrame   = !pause && lastBeat && curEof;
                pushDataError        = !pause && lastBeat && curEof && curErr;
                if (!pause && lastBeat && !load) stateNext = (curEof && gapOn) ? GAP : IDLE;
            end
            GAP: begin
                if (gapCnt == '0) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gapCnt <= '0;
        end else if (state != GAP) begin
            gapCnt <= gapW'(gapLoad);
        end else begin
            gapCnt <= gapCnt - 1'b1;
        end
    end

    // frame bookkeeping is settled at word acceptance; the per-word flags ride with the shifter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outOfReset <= 1'b0;
            inFrame    <= 1'b0;
            dropping   <= 1'b0;
            frameErr   <= 1'b0;
            wordCount  <= '0;
            curSof     <= 1'b0;
            curEof     <= 1'b0;
            curErr     <= 1'b0;
        end else begin
            outOfReset <= 1'b1;
            if (accept && drop) begin
                if (dropping && wordEof) dropping <= 1'b0;
            end else if (load) begin
                curSof    <= sofStart;
                curEof    <= wordEnds;
                curErr    <= wordBad;
                inFrame   <= !wordEnds;
                wordCount <= wordEnds ? '0 : nextCount;
                frameErr  <= !wordEnds && (frameErr || lateSof);
                dropping  <= forcedEnd;
            end
        end
    end

`ifdef PORT_TX_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            txFrameCount       <= '0;
            txErrorFrameCount  <= '0;
            txDroppedWordCount <= '0;
        end else begin
            if (pushDataEndOfFrame) txFrameCount      <= txFrameCount + 1'b1;
            if (pushDataError)      txErrorFrameCount <= txErrorFrameCount + 1'b1;
            if (accept && drop)     txDroppedWordCount <= txDroppedWordCount + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_port_frame_transmitter.sv
// tb/tb_port_frame_transmitter.sv - self-checking bench for port_frame_transmitter
module tb_port_frame_transmitter;

    localparam int MAXW = 4;

    logic        clk, rstn;
    logic [31:0] wordData;
    logic        wordValid, wordReady, wordSof, wordEof, wordError, pause;
    logic [7:0]  pushData;
    logic        push, pushDataStartOfFrame, pushDataEndOfFrame, pushDataError, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
        logic       er;
    } beat_t;

    beat_t      expQ[$];
    bit         mInFrame, mDropping, mFrameErr;
    int         mCount;

    logic [7:0] logData[$];
    int         logCyc[$];
    bit         logSof[$], logEof[$], logErr[$];

    port_frame_transmitter #(
        .serialWidth     (8),
        .parrallelWidth  (32),
        .interFrameGap   (2),
        .maxWordsPerFrame(MAXW)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .wordData            (wordData),
        .wordValid           (wordValid),
        .wordReady           (wordReady),
        .wordSof             (wordSof),
        .wordEof             (wordEof),
        .wordError           (wordError),
        .pause               (pause),
        .pushData            (pushData),
        .push                (push),
        .pushDataStartOfFrame(pushDataStartOfFrame),
        .pushDataEndOfFrame  (pushDataEndOfFrame),
        .pushDataError       (pushDataError),
        .busy                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // expected beats from the frame rules: who starts a frame, where it ends, and whether it is bad
    task automatic modelAccept(input logic [31:0] d, input bit s, input bit e, input bit er);
        int  n;
        bit  late, forced, ends, bad;
        beat_t b;
        if (mDropping || (!mInFrame && !s)) begin
            if (mDropping && e) mDropping = 0;
            return;
        end
        n      = mInFrame ? mCount + 1 : 1;
        late   = s && mInFrame;
        forced = (n == MAXW) && !e;
        ends   = e || forced;
        bad    = (e && er) || mFrameErr || late || forced;
        for (int i = 0; i < 4; i++) begin
            b.d  = d[i*8 +: 8];
            b.s  = (i == 0) && s && !mInFrame;
            b.e  = (i == 3) && ends;
            b.er = (i == 3) && ends && bad;
            expQ.push_back(b);
        end
        if (ends) begin
            mInFrame = 0; mCount = 0; mFrameErr = 0;
        end else begin
            mInFrame = 1; mCount = n; mFrameErr = mFrameErr || late;
        end
        mDropping = forced;
    endtask

    always @(negedge clk) begin
        beat_t eb;
        if (!rstn) begin
            expQ.delete();
            mInFrame = 0; mDropping = 0; mFrameErr = 0; mCount = 0;
        end else begin
            if (pause) check("push_while_pause", {31'd0, push}, 32'd0);
            if (push) begin
                logData.push_back(pushData);
                logCyc.push_back(cyc);
                logSof.push_back(pushDataStartOfFrame);
                logEof.push_back(pushDataEndOfFrame);
                logErr.push_back(pushDataError);
                if (expQ.size() == 0) begin
                    check("unexpected_push", 32'd1, 32'd0);
                end else begin
                    eb = expQ.pop_front();
                    check("beat_data", {24'd0, pushData}, {24'd0, eb.d});
                    check("beat_sof", {31'd0, pushDataStartOfFrame}, {31'd0, eb.s});
                    check("beat_eof", {31'd0, pushDataEndOfFrame}, {31'd0, eb.e});
                    check("beat_err", {31'd0, pushDataError}, {31'd0, eb.er});
                end
            end else begin
                check("idle_flags", {29'd0, pushDataStartOfFrame, pushDataEndOfFrame, pushDataError}, 32'd0);
            end
            if (wordValid && wordReady) modelAccept(wordData, wordSof, wordEof, wordError);
        end
    end

    task automatic clearLog();
        logData.delete(); logCyc.delete(); logSof.delete(); logEof.delete(); logErr.delete();
    endtask

    task automatic sendWord(input logic [31:0] d, input bit s, input bit e, input bit er);
        int n;
        n = 0;
        wordData = d; wordSof = s; wordEof = e; wordError = er; wordValid = 1'b1;
        @(negedge clk);
        while (!wordReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        wordValid = 1'b0; wordSof = 1'b0; wordEof = 1'b0; wordError = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(wordReady && !busy && expQ.size() == 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("idle_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic int countBits(input bit q[$]);
        int c = 0;
        foreach (q[i]) c += q[i];
        return c;
    endfunction

    initial begin
        logic [7:0] t1Exp [4];
        t1Exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        rstn = 1'b0; wordData = '0; wordValid = 0; wordSof = 0; wordEof = 0; wordError = 0; pause = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_push", {31'd0, push}, 32'd0);
        check("rst_data", {24'd0, pushData}, 32'd0);
        check("rst_flags", {29'd0, pushDataStartOfFrame, pushDataEndOfFrame, pushDataError}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {31'd0, wordReady}, 32'd1);

        // single-word frame: latency, beat order, flags and gap
        clearLog();
        sendWord(32'hDDCCBBAA, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_push", {31'd0, push}, 32'd1);
            check("t1_data", {24'd0, pushData}, {24'd0, t1Exp[i]});
            check("t1_sof", {31'd0, pushDataStartOfFrame}, (i == 0) ? 32'd1 : 32'd0);
            check("t1_eof", {31'd0, pushDataEndOfFrame}, (i == 3) ? 32'd1 : 32'd0);
            check("t1_err", {31'd0, pushDataError}, 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t1_gap_ready", {31'd0, wordReady}, 32'd0);
            check("t1_gap_push", {31'd0, push}, 32'd0);
        end
        @(negedge clk);
        check("t1_ready_after_gap", {31'd0, wordReady}, 32'd1);
        waitIdle();

        // 3-word frame back-to-back: no bubble
        clearLog();
        sendWord(32'h13121110, 1, 0, 0);
        sendWord(32'h23222120, 0, 0, 0);
        sendWord(32'h33323130, 0, 1, 0);
        waitIdle();
        check("t2_beats", logData.size(), 32'd12);
        if (logData.size() == 12) begin
            check("t2_span", logCyc[11] - logCyc[0], 32'd11);
            check("t2_sof0", {31'd0, logSof[0]}, 32'd1);
            check("t2_eof11", {31'd0, logEof[11]}, 32'd1);
            check("t2_data4", {24'd0, logData[4]}, 32'h20);
            check("t2_data11", {24'd0, logData[11]}, 32'h33);
        end
        check("t2_sof_count", countBits(logSof), 32'd1);
        check("t2_eof_count", countBits(logEof), 32'd1);

        // pause during beat 1
        clearLog();
        sendWord(32'h44332211, 1, 1, 0);
        @(posedge clk);
        #1 pause = 1'b1;
        repeat (3) @(posedge clk);
        #1 pause = 1'b0;
        waitIdle();
        check("t3_beats", logData.size(), 32'd4);
        if (logData.size() == 4) begin
            check("t3_beat1_delay", logCyc[1] - logCyc[0], 32'd4);
            check("t3_span", logCyc[3] - logCyc[0], 32'd6);
            check("t3_beat1", {24'd0, logData[1]}, 32'h22);
            check("t3_beat3", {24'd0, logData[3]}, 32'h44);
        end

        // word without SOF is swallowed, then a normal frame
        clearLog();
        sendWord(32'h12345678, 0, 0, 0);
        repeat (6) @(posedge clk);
        #1;
        check("t4_no_push", logData.size(), 32'd0);
        check("t4_ready", {31'd0, wordReady}, 32'd1);
        sendWord(32'h87654321, 1, 1, 0);
        waitIdle();
        check("t4_beats", logData.size(), 32'd4);
        if (logData.size() == 4) check("t4_first", {24'd0, logData[0]}, 32'h21);

        // 6-word frame against a 4-word limit
        clearLog();
        for (int w = 1; w <= 6; w++) sendWord(32'h01010101 * w, (w == 1), (w == 6), 0);
        waitIdle();
        check("t5_beats", logData.size(), 32'd16);
        if (logData.size() == 16) begin
            check("t5_eof15", {31'd0, logEof[15]}, 32'd1);
            check("t5_err15", {31'd0, logErr[15]}, 32'd1);
            check("t5_data15", {24'd0, logData[15]}, 32'h04);
        end
        check("t5_eof_count", countBits(logEof), 32'd1);
        clearLog();
        sendWord(32'h0D0C0B0A, 1, 1, 0);
        waitIdle();
        check("t5_clean_beats", logData.size(), 32'd4);
        if (logData.size() == 4) begin
            check("t5_clean_sof", {31'd0, logSof[0]}, 32'd1);
            check("t5_clean_eof", {31'd0, logEof[3]}, 32'd1);
            check("t5_clean_err", {31'd0, logErr[3]}, 32'd0);
        end

        // reset during beat 2 abandons the frame
        clearLog();
        sendWord(32'hA1B2C3D4, 1, 0, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("t6_push", {31'd0, push}, 32'd0);
        check("t6_data", {24'd0, pushData}, 32'd0);
        check("t6_flags", {29'd0, pushDataStartOfFrame, pushDataEndOfFrame, pushDataError}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        check("t6_ready", {31'd0, wordReady}, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        check("t6_beats_before_reset", logData.size(), 32'd2);
        check("t6_no_eof", countBits(logEof), 32'd0);
        check("final_queue_empty", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
